snake_engine: RTL

Game-logic and pixel-colour stage directly downstream of the 640x480 VGA timing generator. Consumes the generator's pixel position, active flag and end-of-active-frame tick. Holds snake body, food and game state, advances the snake once every STEP_FRAMES frames, and produces one registered 8-bit RRRGGGBB colour per pixel strobe for the DAC pins. The playfield is a 40x30 grid of 16x16-pixel tiles.

---
 rtl/snake_engine.sv | 108 ++++++++++
 1 files changed

// File: rtl/snake_engine.sv
// snake_engine: snake game state and registered per-pixel colour for a 640x480 VGA pipeline
module snake_engine #(
    parameter int STEP_FRAMES = 8,
    parameter int MAX_LEN = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_stb,
    input  logic       i_animate,
    input  logic       i_active,
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    input  logic [3:0] i_btn,
    output logic [7:0] o_rgb,
    output logic [7:0] o_score,
    output logic       o_game_over
);
    localparam int LW = $clog2(MAX_LEN + 1);
    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;
    state_t state_q, state_d;
    dir_t cur_dir_q, cur_dir_d, pend_dir_q, pend_dir_d, req;
    logic [7:0] fcnt_q, fcnt_d, score_q, score_d, rgb_q, rgb_d;
    logic [LW-1:0] len_q, len_d;
    logic [10:0] seg_q [MAX_LEN];
    logic [10:0] seg_d [MAX_LEN];
    logic [10:0] food_q, food_d, nhead, pix;
    logic [15:0] lfsr_q, lfsr_d;
    logic [6:0] ncol;
    logic [5:0] nrow, fcol;
    logic [4:0] frow;
    logic ftick, step, wall, self_hit, eat, head_px, body_px, unused_sub_tile;
    assign unused_sub_tile = ^{i_x[3:0], i_y[3:0]};
    assign o_rgb = rgb_q;
    assign o_score = score_q;
    assign o_game_over = state_q == OVER;
    // game step, direction filtering, food relocation and pixel colour selection
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        fcol = lfsr_q[5:0] < 6'd40 ? lfsr_q[5:0] : lfsr_q[5:0] - 6'd40;
        frow = lfsr_q[12:8] < 5'd30 ? lfsr_q[12:8] : lfsr_q[12:8] - 5'd30;
        req = i_btn[3] ? D_UP : i_btn[2] ? D_DOWN : i_btn[1] ? D_LEFT : D_RIGHT;
        ncol = {1'b0, seg_q[0][10:5]} + (pend_dir_q == D_RIGHT ? 7'd1 : pend_dir_q == D_LEFT ? 7'h7F : 7'd0);
        nrow = {1'b0, seg_q[0][4:0]} + (pend_dir_q == D_DOWN ? 6'd1 : pend_dir_q == D_UP ? 6'h3F : 6'd0);
        nhead = {ncol[5:0], nrow[4:0]};
        wall = ncol > 7'd39 || nrow > 6'd29;
        pix = {i_x[9:4], i_y[8:4]};
        self_hit = 1'b0;
        body_px = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            self_hit = self_hit | ((i < int'(len_q) - 1) && seg_q[i] == nhead);
            body_px = body_px | ((i > 0) && (i < int'(len_q)) && seg_q[i] == pix);
        end
        head_px = seg_q[0] == pix;
        eat = nhead == food_q;
        ftick = i_animate & i_pix_stb;
        step = state_q == RUN && ftick && fcnt_q == 8'(STEP_FRAMES - 1);
        state_d = state_q == IDLE && |i_btn ? RUN : state_q;
        pend_dir_d = (|i_btn && req != dir_t'(cur_dir_q ^ 2'd1)) ? req : pend_dir_q;
        cur_dir_d = step ? pend_dir_q : cur_dir_q;
        fcnt_d = state_q == RUN && ftick ? (step ? 8'd0 : fcnt_q + 8'd1) : fcnt_q;
        len_d = len_q;
        score_d = score_q;
        food_d = food_q;
        seg_d = seg_q;
        if (step) begin
            if (wall || self_hit) begin
                state_d = OVER;
            end else begin
                for (int i = MAX_LEN - 1; i > 0; i--) seg_d[i] = seg_q[i-1];
                seg_d[0] = nhead;
                if (eat) begin
                    len_d = len_q == LW'(MAX_LEN) ? len_q : len_q + 1'b1;
                    score_d = score_q == 8'hFF ? score_q : score_q + 8'd1;
                    food_d = {fcol, frow};
                end
            end
        end
        rgb_d = !i_pix_stb ? rgb_q : !i_active ? 8'h00 : head_px ? 8'hFC : body_px ? 8'h1C :
                food_q == pix ? 8'hE0 : state_q == OVER ? 8'h40 : 8'h00;
    end
    // state registers with synchronous reset to the starting layout
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cur_dir_q <= D_RIGHT;
            pend_dir_q <= D_RIGHT;
            fcnt_q <= 8'd0;
            score_q <= 8'd0;
            rgb_q <= 8'h00;
            len_q <= LW'(3);
            food_q <= {6'd30, 5'd15};
            lfsr_q <= 16'hACE1;
            for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= i < 3 ? {6'(20 - i), 5'd15} : 11'd0;
        end else begin
            state_q <= state_d;
            cur_dir_q <= cur_dir_d;
            pend_dir_q <= pend_dir_d;
            fcnt_q <= fcnt_d;
            score_q <= score_d;
            rgb_q <= rgb_d;
            len_q <= len_d;
            food_q <= food_d;
            lfsr_q <= lfsr_d;
            seg_q <= seg_d;
        end
    end
endmodule
